// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, standard 640x480 timing constants and total-length helpers.
package vga_timing_pkg;

  // One axis of a video timing: display, front porch, sync and back porch lengths.
  typedef struct packed {
    int disp;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t VGA_640X480_H = '{disp: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA_640X480_V = '{disp: 480, fp: 10, sync: 2,  bp: 33};

  // Full line length in pixels, blanking included.
  function automatic int h_total(timing_t t);
    return t.disp + t.fp + t.sync + t.bp;
  endfunction

  // Full frame length in lines, blanking included.
  function automatic int v_total(timing_t t);
    return t.disp + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Control and timing bundle between the VGA timing core (master) and its consumer (slave).
interface vga_timing_gen_if #(
  parameter int COUNT_W = 11,
  parameter int FRAME_W = 16
);
  logic               enable;
  logic               sync_clr;
  logic               pixel_tick;
  logic [COUNT_W-1:0] hcount;
  logic [COUNT_W-1:0] vcount;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               line_start;
  logic               frame_start;
  logic               frame_end;
  logic               frame_tick;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  enable, sync_clr,
    output pixel_tick, hcount, vcount, hsync, vsync, video_on,
           line_start, frame_start, frame_end, frame_tick, frame_count
  );

  modport slave (
    output enable, sync_clr,
    input  pixel_tick, hcount, vcount, hsync, vsync, video_on,
           line_start, frame_start, frame_end, frame_tick, frame_count
  );
endinterface

// File: rtl/vga_pixel_prescaler.sv
// Divides the system clock down to a one-cycle pixel strobe every CLK_DIV cycles.
module vga_pixel_prescaler #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable_i,
  input  logic sync_clr_i,
  output logic pixel_tick_o
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Divider advances only while enabled, so a pause resumes mid-period; restart returns to phase 0.
  always_comb begin
    div_d = div_q;
    if (sync_clr_i) begin
      div_d = '0;
    end else if (enable_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // With CLK_DIV==1 div_q stays 0 and the strobe follows enable; held off while in reset.
  assign pixel_tick_o = reset_n && enable_i && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing core: full-frame H/V counters, registered sync/blank decode, position strobes, frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = VGA_640X480_H.disp,
  parameter int H_FP    = VGA_640X480_H.fp,
  parameter int H_SYNC  = VGA_640X480_H.sync,
  parameter int H_BP    = VGA_640X480_H.bp,
  parameter int V_DISP  = VGA_640X480_V.disp,
  parameter int V_FP    = VGA_640X480_V.fp,
  parameter int V_SYNC  = VGA_640X480_V.sync,
  parameter int V_BP    = VGA_640X480_V.bp,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0,
  parameter int COUNT_W = 11,
  parameter int FRAME_W = 16
) (
  input logic clk,
  input logic reset_n,
  vga_timing_gen_if.master bus
);
  localparam timing_t H_T = '{disp: H_DISP, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t V_T = '{disp: V_DISP, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int H_TOTAL  = h_total(H_T);
  localparam int V_TOTAL  = v_total(V_T);
  localparam int HS_START = H_DISP + H_FP;
  localparam int VS_START = V_DISP + V_FP;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if ((2 ** COUNT_W) < H_TOTAL || (2 ** COUNT_W) < V_TOTAL) begin : g_bad_width
    $error("vga_timing_gen: COUNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [COUNT_W-1:0] hcount_q, hcount_d;
  logic [COUNT_W-1:0] vcount_q, vcount_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d, frame_end_q, frame_end_d;
  logic h_last, v_last, frame_tick;

  vga_pixel_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable_i    (bus.enable),
    .sync_clr_i  (bus.sync_clr),
    .pixel_tick_o(bus.pixel_tick)
  );

  assign h_last = (int'(hcount_q) == H_TOTAL - 1);
  assign v_last = (int'(vcount_q) == V_TOTAL - 1);
  // A restart on the last pixel abandons the frame, so it is not counted.
  assign frame_tick = bus.pixel_tick && h_last && v_last && !bus.sync_clr;

  // Next counter position, then decode of that position so outputs line up with the counters.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (bus.sync_clr) begin
      hcount_d = '0;
      vcount_d = '0;
    end else if (bus.pixel_tick) begin
      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + COUNT_W'(1);
      end else begin
        hcount_d = hcount_q + COUNT_W'(1);
      end
    end
    frame_count_d = frame_tick ? frame_count_q + FRAME_W'(1) : frame_count_q;
    video_on_d    = (int'(hcount_d) < H_DISP) && (int'(vcount_d) < V_DISP);
    hsync_d       = (int'(hcount_d) >= HS_START && int'(hcount_d) < HS_START + H_SYNC) ? H_POL : ~H_POL;
    vsync_d       = (int'(vcount_d) >= VS_START && int'(vcount_d) < VS_START + V_SYNC) ? V_POL : ~V_POL;
    line_start_d  = (hcount_d == '0);
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    frame_end_d   = (int'(hcount_d) == H_TOTAL - 1) && (int'(vcount_d) == V_TOTAL - 1);
  end

  // Counter, frame counter and decoded output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_count_q <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign bus.hcount      = hcount_q;
  assign bus.vcount      = vcount_q;
  assign bus.frame_count = frame_count_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.frame_tick  = frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 15x8 timing (A: CLK_DIV=4) and a CLK_DIV=1, FRAME_W=2 copy (B).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n_a;
  logic reset_n_b;

  vga_timing_gen_if #(.COUNT_W(4), .FRAME_W(16)) a_if ();
  vga_timing_gen_if #(.COUNT_W(4), .FRAME_W(2))  b_if ();

  vga_timing_gen #(
    .CLK_DIV(4), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .COUNT_W(4), .FRAME_W(16)
  ) u_dut_a (
    .clk    (clk),
    .reset_n(reset_n_a),
    .bus    (a_if)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .COUNT_W(4), .FRAME_W(2)
  ) u_dut_b (
    .clk    (clk),
    .reset_n(reset_n_b),
    .bus    (b_if)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    total++;
    if (val_q.size() == 0) begin
      $error("FAIL sb_underflow observed=%0d required=none", obs);
      return;
    end
    t = tag_q.pop_front();
    e = val_q.pop_front();
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%0d required=%0d", t, obs, e);
  endtask

  task automatic bound_fail(input string t);
    total++;
    $error("FAIL %s observed=timeout required=event", t);
  endtask

  task automatic wait_pos_a(input int h, input int v, input int budget);
    int n = 0;
    while (!(int'(a_if.hcount) == h && int'(a_if.vcount) == v)) begin
      if (n >= budget) begin
        bound_fail($sformatf("wait_pos_%0d_%0d", h, v));
        return;
      end
      tick(1);
      n++;
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return a_if.pixel_tick;
      1:       return a_if.frame_tick;
      default: return b_if.frame_tick;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int budget, input string t);
    int n = 0;
    while (get_sig(sel) !== 1'b1) begin
      if (n >= budget) begin
        bound_fail(t);
        return;
      end
      tick(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;
    int n;
    int lo;
    int von;

    // ---- reset held 3 clocks ----
    reset_n_a = 1'b0; reset_n_b = 1'b0;
    a_if.enable = 1'b1; a_if.sync_clr = 1'b0;
    b_if.enable = 1'b1; b_if.sync_clr = 1'b0;
    expect_v("rst_hcount", 0); expect_v("rst_vcount", 0); expect_v("rst_hsync", 1);
    expect_v("rst_vsync", 1);  expect_v("rst_video_on", 0); expect_v("rst_frame_count", 0);
    expect_v("rst_frame_start", 0); expect_v("rst_pixel_tick", 0);
    tick(3);
    chk(32'(a_if.hcount)); chk(32'(a_if.vcount)); chk(32'(a_if.hsync));
    chk(32'(a_if.vsync));  chk(32'(a_if.video_on)); chk(32'(a_if.frame_count));
    chk(32'(a_if.frame_start)); chk(32'(a_if.pixel_tick));

    // ---- release: first edge loads decode of (0,0) ----
    reset_n_a = 1'b1;
    rel = cyc;
    expect_v("rel_video_on", 1); expect_v("rel_frame_start", 1);
    expect_v("rel_line_start", 1); expect_v("rel_hcount", 0);
    tick(1);
    chk(32'(a_if.video_on)); chk(32'(a_if.frame_start));
    chk(32'(a_if.line_start)); chk(32'(a_if.hcount));

    // ---- pixel_tick once every 4 clocks ----
    expect_v("tick_count_40clk", 10);
    n = 0;
    repeat (40) begin
      tick(1);
      n += int'(a_if.pixel_tick);
    end
    chk(32'(n));

    // ---- one full line: hsync low 3 pixels, video_on high 8 pixels ----
    expect_v("hsync_low_clks", 12); expect_v("video_on_clks", 32);
    wait_pos_a(0, 1, 600);
    lo = 0; von = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_if.hsync === 1'b0) lo++;
      if (a_if.video_on === 1'b1) von++;
      if (i < 59) tick(1);
    end
    chk(32'(lo)); chk(32'(von));

    // ---- horizontal boundaries ----
    wait_pos_a(7, 2, 600);
    expect_v("h7_video_on", 1); expect_v("h7_hsync", 1);
    chk(32'(a_if.video_on)); chk(32'(a_if.hsync));
    wait_pos_a(8, 2, 600);
    expect_v("h8_video_on", 0); expect_v("h8_hsync", 1);
    chk(32'(a_if.video_on)); chk(32'(a_if.hsync));
    wait_pos_a(10, 2, 600);
    expect_v("h10_hsync", 0); expect_v("h10_line_start", 0);
    chk(32'(a_if.hsync)); chk(32'(a_if.line_start));
    wait_pos_a(12, 2, 600);
    expect_v("h12_hsync", 0); chk(32'(a_if.hsync));
    wait_pos_a(13, 2, 600);
    expect_v("h13_hsync", 1); chk(32'(a_if.hsync));

    // ---- vertical boundaries ----
    wait_pos_a(0, 4, 600);
    expect_v("v4_video_on", 0); expect_v("v4_line_start", 1); expect_v("v4_vsync", 1);
    chk(32'(a_if.video_on)); chk(32'(a_if.line_start)); chk(32'(a_if.vsync));
    wait_pos_a(0, 5, 600);
    expect_v("v5_vsync", 0); chk(32'(a_if.vsync));
    wait_pos_a(14, 6, 600);
    expect_v("v6_vsync", 0); chk(32'(a_if.vsync));
    wait_pos_a(0, 7, 600);
    expect_v("v7_vsync", 1); chk(32'(a_if.vsync));

    // ---- end of first frame: 15*8*4 = 480 clocks ----
    wait_pos_a(14, 7, 600);
    expect_v("last_frame_end", 1); expect_v("last_frame_count", 0);
    chk(32'(a_if.frame_end)); chk(32'(a_if.frame_count));
    expect_v("frame_tick_cycle", 32'(rel + 479));
    wait_sig(1, 8, "wait_frame_tick_a");
    chk(32'(cyc));
    expect_v("wrap_frame_count", 1); expect_v("wrap_hcount", 0); expect_v("wrap_vcount", 0);
    expect_v("wrap_frame_start", 1); expect_v("wrap_frame_end", 0);
    tick(1);
    chk(32'(a_if.frame_count)); chk(32'(a_if.hcount)); chk(32'(a_if.vcount));
    chk(32'(a_if.frame_start)); chk(32'(a_if.frame_end));

    // ---- sync_clr mid-frame ----
    wait_pos_a(9, 2, 600);
    a_if.sync_clr = 1'b1;
    expect_v("clr_hcount", 0); expect_v("clr_vcount", 0); expect_v("clr_frame_start", 1);
    expect_v("clr_frame_count", 1); expect_v("clr_video_on", 1);
    tick(1);
    a_if.sync_clr = 1'b0;
    chk(32'(a_if.hcount)); chk(32'(a_if.vcount)); chk(32'(a_if.frame_start));
    chk(32'(a_if.frame_count)); chk(32'(a_if.video_on));

    // ---- enable low 10 clocks just before hsync ----
    wait_pos_a(9, 0, 600);
    wait_sig(0, 8, "wait_pixel_tick_h9");
    a_if.enable = 1'b0;
    #1;
    expect_v("dis_pixel_tick_now", 0); chk(32'(a_if.pixel_tick));
    expect_v("dis_hcount", 9); expect_v("dis_hsync", 1); expect_v("dis_video_on", 0);
    expect_v("dis_pixel_tick", 0); expect_v("dis_vcount", 0);
    tick(10);
    chk(32'(a_if.hcount)); chk(32'(a_if.hsync)); chk(32'(a_if.video_on));
    chk(32'(a_if.pixel_tick)); chk(32'(a_if.vcount));
    a_if.enable = 1'b1;
    #1;
    expect_v("resume_pixel_tick", 1); chk(32'(a_if.pixel_tick));
    expect_v("resume_hcount", 10); expect_v("resume_hsync", 0);
    tick(1);
    chk(32'(a_if.hcount)); chk(32'(a_if.hsync));

    // ---- sync_clr on the last-pixel tick suppresses frame_tick ----
    wait_pos_a(14, 7, 600);
    wait_sig(0, 8, "wait_pixel_tick_last");
    a_if.sync_clr = 1'b1;
    #1;
    expect_v("clr_last_frame_tick", 0); chk(32'(a_if.frame_tick));
    expect_v("clr_last_frame_count", 1); expect_v("clr_last_hcount", 0); expect_v("clr_last_vcount", 0);
    tick(1);
    a_if.sync_clr = 1'b0;
    chk(32'(a_if.frame_count)); chk(32'(a_if.hcount)); chk(32'(a_if.vcount));

    // ---- reset mid-frame ----
    wait_pos_a(5, 3, 600);
    expect_v("mid_rst_hcount", 0); expect_v("mid_rst_vcount", 0); expect_v("mid_rst_hsync", 1);
    expect_v("mid_rst_vsync", 1);  expect_v("mid_rst_video_on", 0); expect_v("mid_rst_frame_count", 0);
    expect_v("mid_rst_frame_start", 0);
    reset_n_a = 1'b0;
    tick(3);
    chk(32'(a_if.hcount)); chk(32'(a_if.vcount)); chk(32'(a_if.hsync));
    chk(32'(a_if.vsync));  chk(32'(a_if.video_on)); chk(32'(a_if.frame_count));
    chk(32'(a_if.frame_start));

    // ---- instance B: CLK_DIV=1, FRAME_W=2 ----
    expect_v("b_pixel_tick_count", 20);
    expect_v("b_frame_count_1", 1); expect_v("b_frame_count_2", 2); expect_v("b_frame_count_3", 3);
    expect_v("b_frame_count_4", 0); expect_v("b_frame_count_5", 1);
    reset_n_b = 1'b1;
    tick(1);
    n = 0;
    repeat (20) begin
      n += int'(b_if.pixel_tick);
      tick(1);
    end
    chk(32'(n));
    for (int f = 0; f < 5; f++) begin
      wait_sig(2, 200, $sformatf("wait_frame_tick_b_%0d", f + 1));
      tick(1);
      chk(32'(b_if.frame_count));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
